// File: rtl/ctl_pkg.sv
// Shared definitions for the ID..WB control-word pipeline.
//   - Bit positions of each field inside the 8-bit control word from the decoder.
//   - Encodings of the EX-stage forwarding selects.
//   - The bubble (nop) control word.
package ctl_pkg;

  // Control word field map
  localparam int unsigned CTL_ALUSRC    = 7;
  localparam int unsigned CTL_MEMTOREG  = 6;
  localparam int unsigned CTL_REGWRITE  = 5;
  localparam int unsigned CTL_MEMREAD   = 4;
  localparam int unsigned CTL_MEMWRITE  = 3;
  localparam int unsigned CTL_BRANCH    = 2;
  localparam int unsigned CTL_ALUOP_MSB = 1;
  localparam int unsigned CTL_ALUOP_LSB = 0;

  // Forwarding mux selects for ALU operands A/B
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // A bubble is exactly an all-zero control word (nop)
  localparam logic [7:0] CTL_BUBBLE = 8'h00;

endpackage

// File: rtl/ctl_pipe_if.sv
// Bus between the ID-stage decoder / datapath and the control pipeline.
//   master: decoder side, drives the ID-stage control word, register indices and flush,
//           consumes stall, per-stage strobes and forwarding selects.
//   slave:  ctl_pipe itself.
interface ctl_pipe_if #(
  parameter int unsigned CTL_W = 8,
  parameter int unsigned RA_W  = 5
);

  // ID stage inputs
  logic [CTL_W-1:0] ctl_id;
  logic [RA_W-1:0]  rs1_id;
  logic [RA_W-1:0]  rs2_id;
  logic [RA_W-1:0]  rd_id;
  logic             flush;

  // Hazard / EX stage
  logic             stall;
  logic             ex_alu_src;
  logic [1:0]       ex_alu_op;
  logic             ex_branch;
  logic [RA_W-1:0]  ex_rs1;
  logic [RA_W-1:0]  ex_rs2;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  // MEM stage
  logic             mem_read;
  logic             mem_write;

  // WB stage
  logic             wb_reg_write;
  logic             wb_mem_to_reg;
  logic [RA_W-1:0]  wb_rd;

  modport master (
    output ctl_id, rs1_id, rs2_id, rd_id, flush,
    input  stall, ex_alu_src, ex_alu_op, ex_branch, ex_rs1, ex_rs2, fwd_a, fwd_b,
    input  mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_rd
  );

  modport slave (
    input  ctl_id, rs1_id, rs2_id, rd_id, flush,
    output stall, ex_alu_src, ex_alu_op, ex_branch, ex_rs1, ex_rs2, fwd_a, fwd_b,
    output mem_read, mem_write, wb_reg_write, wb_mem_to_reg, wb_rd
  );

endinterface

// File: rtl/fwd_unit.sv
// EX-stage forwarding unit, purely combinational.
//   ex_rs1/ex_rs2     : source indices of the instruction in EX
//   exmem_reg_write/rd: destination of the instruction in MEM
//   memwb_reg_write/rd: destination of the instruction in WB
//   fwd_a/fwd_b       : operand A/B select (00 regfile, 10 EX/MEM, 01 MEM/WB)
module fwd_unit
  import ctl_pkg::*;
#(
  parameter int unsigned RA_W = 5
) (
  input  logic [RA_W-1:0] ex_rs1,
  input  logic [RA_W-1:0] ex_rs2,
  input  logic            exmem_reg_write,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic            memwb_reg_write,
  input  logic [RA_W-1:0] memwb_rd,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b
);

  // EX/MEM is checked first: it holds the newest value of a register written twice in a row.
  // x0 is hard-wired zero, so a destination of 0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic            src_is_exmem_wr,
    input logic [RA_W-1:0] e_rd,
    input logic            src_is_memwb_wr,
    input logic [RA_W-1:0] m_rd,
    input logic [RA_W-1:0] src
  );
    if (src_is_exmem_wr && (e_rd != '0) && (e_rd == src)) begin
      return FWD_EXMEM;
    end else if (src_is_memwb_wr && (m_rd != '0) && (m_rd == src)) begin
      return FWD_MEMWB;
    end else begin
      return FWD_RF;
    end
  endfunction

  always_comb begin
    fwd_a = fwd_sel(exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd, ex_rs1);
    fwd_b = fwd_sel(exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd, ex_rs2);
  end

endmodule

// File: rtl/ctl_pipe.sv
// Control-word pipeline for the 5-stage RV32I core.
// Carries the decoder's control word and register indices through ID/EX, EX/MEM and MEM/WB,
// slices it into per-stage strobes, and generates the load-use stall, flush bubbles and
// EX-stage forwarding selects.
//   clk   : pipeline clock, rising edge
//   reset : synchronous, active-high; clears every stage register
//   bus   : slave side of ctl_pipe_if (ID inputs, flush in; stall, EX/MEM/WB strobes out)
module ctl_pipe
  import ctl_pkg::*;
#(
  parameter int unsigned CTL_W = 8,
  parameter int unsigned RA_W  = 5
) (
  input logic        clk,
  input logic        reset,
  ctl_pipe_if.slave  bus
);

  // ID/EX
  logic [CTL_W-1:0] idex_ctl_q, idex_ctl_d;
  logic [RA_W-1:0]  idex_rs1_q, idex_rs1_d;
  logic [RA_W-1:0]  idex_rs2_q, idex_rs2_d;
  logic [RA_W-1:0]  idex_rd_q, idex_rd_d;

  // EX/MEM: the branch bit resolves in EX, so only the MEM and WB fields travel on
  logic             exmem_mem_to_reg_q;
  logic             exmem_reg_write_q;
  logic             exmem_mem_read_q;
  logic             exmem_mem_write_q;
  logic [RA_W-1:0]  exmem_rd_q;

  // MEM/WB
  logic             memwb_mem_to_reg_q;
  logic             memwb_reg_write_q;
  logic [RA_W-1:0]  memwb_rd_q;

  logic             load_use;
  logic             bubble;

  // A load in EX whose destination is read by the ID instruction cannot forward in time.
  // A taken branch kills the ID instruction anyway, so flush suppresses the hold.
  always_comb begin
    load_use = idex_ctl_q[CTL_MEMREAD] && (idex_rd_q != '0) &&
               ((idex_rd_q == bus.rs1_id) || (idex_rd_q == bus.rs2_id));
    bubble   = bus.flush || load_use;
  end

  always_comb begin
    idex_ctl_d = bus.ctl_id;
    idex_rs1_d = bus.rs1_id;
    idex_rs2_d = bus.rs2_id;
    idex_rd_d  = bus.rd_id;
    if (bubble) begin
      idex_ctl_d = CTL_W'(CTL_BUBBLE);
      idex_rs1_d = '0;
      idex_rs2_d = '0;
      idex_rd_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_ctl_q         <= '0;
      idex_rs1_q         <= '0;
      idex_rs2_q         <= '0;
      idex_rd_q          <= '0;
      exmem_mem_to_reg_q <= 1'b0;
      exmem_reg_write_q  <= 1'b0;
      exmem_mem_read_q   <= 1'b0;
      exmem_mem_write_q  <= 1'b0;
      exmem_rd_q         <= '0;
      memwb_mem_to_reg_q <= 1'b0;
      memwb_reg_write_q  <= 1'b0;
      memwb_rd_q         <= '0;
    end else begin
      idex_ctl_q         <= idex_ctl_d;
      idex_rs1_q         <= idex_rs1_d;
      idex_rs2_q         <= idex_rs2_d;
      idex_rd_q          <= idex_rd_d;
      exmem_mem_to_reg_q <= idex_ctl_q[CTL_MEMTOREG];
      exmem_reg_write_q  <= idex_ctl_q[CTL_REGWRITE];
      exmem_mem_read_q   <= idex_ctl_q[CTL_MEMREAD];
      exmem_mem_write_q  <= idex_ctl_q[CTL_MEMWRITE];
      exmem_rd_q         <= idex_rd_q;
      memwb_mem_to_reg_q <= exmem_mem_to_reg_q;
      memwb_reg_write_q  <= exmem_reg_write_q;
      memwb_rd_q         <= exmem_rd_q;
    end
  end

  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  fwd_unit #(
    .RA_W (RA_W)
  ) u_fwd_unit (
    .ex_rs1          (idex_rs1_q),
    .ex_rs2          (idex_rs2_q),
    .exmem_reg_write (exmem_reg_write_q),
    .exmem_rd        (exmem_rd_q),
    .memwb_reg_write (memwb_reg_write_q),
    .memwb_rd        (memwb_rd_q),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b)
  );

  always_comb begin
    bus.stall         = load_use && !bus.flush;
    bus.ex_alu_src    = idex_ctl_q[CTL_ALUSRC];
    bus.ex_alu_op     = idex_ctl_q[CTL_ALUOP_MSB:CTL_ALUOP_LSB];
    bus.ex_branch     = idex_ctl_q[CTL_BRANCH];
    bus.ex_rs1        = idex_rs1_q;
    bus.ex_rs2        = idex_rs2_q;
    bus.fwd_a         = fwd_a;
    bus.fwd_b         = fwd_b;
    bus.mem_read      = exmem_mem_read_q;
    bus.mem_write     = exmem_mem_write_q;
    bus.wb_reg_write  = memwb_reg_write_q;
    bus.wb_mem_to_reg = memwb_mem_to_reg_q;
    bus.wb_rd         = memwb_rd_q;
  end

endmodule

// File: tb/tb_ctl_pipe.sv
// Directed testbench for ctl_pipe: reset, R-type latency, load-use stall, forwarding
// priority and x0, flush, flush-with-stall, and mid-operation reset.
module tb_ctl_pipe;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  ctl_pipe_if #(.CTL_W(8), .RA_W(5)) bus ();

  ctl_pipe #(
    .CTL_W (8),
    .RA_W  (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_drive(input logic [7:0] ctl, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic fl);
    bus.ctl_id = ctl;
    bus.rs1_id = rs1;
    bus.rs2_id = rs2;
    bus.rd_id  = rd;
    bus.flush  = fl;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"},    32'(bus.stall), 0);
    check({tag, "_alusrc"},   32'(bus.ex_alu_src), 0);
    check({tag, "_aluop"},    32'(bus.ex_alu_op), 0);
    check({tag, "_branch"},   32'(bus.ex_branch), 0);
    check({tag, "_exrs1"},    32'(bus.ex_rs1), 0);
    check({tag, "_exrs2"},    32'(bus.ex_rs2), 0);
    check({tag, "_fwda"},     32'(bus.fwd_a), 0);
    check({tag, "_fwdb"},     32'(bus.fwd_b), 0);
    check({tag, "_memrd"},    32'(bus.mem_read), 0);
    check({tag, "_memwr"},    32'(bus.mem_write), 0);
    check({tag, "_wbwr"},     32'(bus.wb_reg_write), 0);
    check({tag, "_wbm2r"},    32'(bus.wb_mem_to_reg), 0);
    check({tag, "_wbrd"},     32'(bus.wb_rd), 0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    // Garbage on ID during reset must not leak into any stage
    id_drive(8'hFF, 5'd0, 5'd0, 5'd9, 1'b0);

    // 1. Reset then R-type
    tick();
    tick();
    check_all_zero("rst");
    reset = 1'b0;
    id_drive(8'h22, 5'd1, 5'd2, 5'd5, 1'b0);
    tick();
    check("r_ex_aluop", 32'(bus.ex_alu_op), 2);
    id_drive(8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    tick();
    check("r_wbwr_early", 32'(bus.wb_reg_write), 0);
    tick();
    check("r_wbwr", 32'(bus.wb_reg_write), 1);
    check("r_wbm2r", 32'(bus.wb_mem_to_reg), 0);
    check("r_wbrd", 32'(bus.wb_rd), 5);

    // 2. Load-use: load x7, then an instruction reading x7
    id_drive(8'hF0, 5'd1, 5'd0, 5'd7, 1'b0);
    check("lu_nostall0", 32'(bus.stall), 0);
    tick();
    id_drive(8'h22, 5'd7, 5'd2, 5'd8, 1'b0);
    check("lu_stall", 32'(bus.stall), 1);
    check("lu_ld_alusrc", 32'(bus.ex_alu_src), 1);
    tick();
    // Dependent instruction held in ID; bubble now in EX
    check("lu_stall_drop", 32'(bus.stall), 0);
    check("lu_bub_aluop", 32'(bus.ex_alu_op), 0);
    check("lu_bub_alusrc", 32'(bus.ex_alu_src), 0);
    check("lu_ld_memrd", 32'(bus.mem_read), 1);
    tick();
    id_drive(8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    check("lu_exrs1", 32'(bus.ex_rs1), 7);
    check("lu_fwda", 32'(bus.fwd_a), 1);
    check("lu_fwdb", 32'(bus.fwd_b), 0);
    check("lu_wbm2r", 32'(bus.wb_mem_to_reg), 1);
    check("lu_wbrd", 32'(bus.wb_rd), 7);
    check("lu_nostall1", 32'(bus.stall), 0);

    // 3. EX/MEM priority: two writes to x3, then read x3 on rs2
    id_drive(8'h22, 5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    id_drive(8'h22, 5'd1, 5'd2, 5'd3, 1'b0);
    tick();
    id_drive(8'h22, 5'd0, 5'd3, 5'd9, 1'b0);
    tick();
    check("fw_fwdb_exmem", 32'(bus.fwd_b), 2);
    check("fw_fwda_rf", 32'(bus.fwd_a), 0);
    // Same again writing x0: never forwards
    id_drive(8'h22, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    id_drive(8'h22, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    id_drive(8'h22, 5'd0, 5'd0, 5'd9, 1'b0);
    tick();
    check("x0_fwdb", 32'(bus.fwd_b), 0);
    check("x0_fwda", 32'(bus.fwd_a), 0);
    id_drive(8'h22, 5'd9, 5'd0, 5'd10, 1'b0);
    tick();
    check("fw_fwda_exmem", 32'(bus.fwd_a), 2);
    // Load into x0 followed by a read of x0: no stall
    id_drive(8'hF0, 5'd1, 5'd0, 5'd0, 1'b0);
    tick();
    id_drive(8'h22, 5'd0, 5'd0, 5'd11, 1'b0);
    check("x0_nostall", 32'(bus.stall), 0);

    // 4. Flush: branch in EX kills the store in ID
    id_drive(8'h05, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    id_drive(8'h88, 5'd1, 5'd2, 5'd0, 1'b1);
    check("fl_branch", 32'(bus.ex_branch), 1);
    check("fl_nostall", 32'(bus.stall), 0);
    tick();
    id_drive(8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    check("fl_bub_alusrc", 32'(bus.ex_alu_src), 0);
    check("fl_bub_branch", 32'(bus.ex_branch), 0);
    check("fl_memwr1", 32'(bus.mem_write), 0);
    tick();
    check("fl_memwr2", 32'(bus.mem_write), 0);

    // 5. Flush together with a load-use condition
    id_drive(8'hF0, 5'd0, 5'd0, 5'd4, 1'b0);
    tick();
    id_drive(8'h22, 5'd4, 5'd0, 5'd10, 1'b0);
    check("fs_stall_noflush", 32'(bus.stall), 1);
    id_drive(8'h22, 5'd4, 5'd0, 5'd10, 1'b1);
    check("fs_stall_flush", 32'(bus.stall), 0);
    tick();
    id_drive(8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    check("fs_bub_aluop", 32'(bus.ex_alu_op), 0);
    check("fs_bub_exrs1", 32'(bus.ex_rs1), 0);
    check("fs_ld_memrd", 32'(bus.mem_read), 1);

    // 6. Mid-operation reset with three instructions in flight
    id_drive(8'h22, 5'd1, 5'd2, 5'd11, 1'b0);
    tick();
    id_drive(8'hF0, 5'd1, 5'd0, 5'd12, 1'b0);
    tick();
    id_drive(8'h88, 5'd1, 5'd2, 5'd0, 1'b0);
    tick();
    check("mr_pre_wbwr", 32'(bus.wb_reg_write), 1);
    check("mr_pre_memrd", 32'(bus.mem_read), 1);
    check("mr_pre_alusrc", 32'(bus.ex_alu_src), 1);
    reset = 1'b1;
    id_drive(8'h22, 5'd1, 5'd2, 5'd13, 1'b0);
    tick();
    check_all_zero("mr");
    reset = 1'b0;
    tick();
    id_drive(8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    check("mr_res_aluop", 32'(bus.ex_alu_op), 2);
    tick();
    tick();
    check("mr_res_wbwr", 32'(bus.wb_reg_write), 1);
    check("mr_res_wbrd", 32'(bus.wb_rd), 13);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
